// File: rtl/ecc_pkg.sv
// Shared definitions for the scalar-multiplication controller and its helpers.
package ecc_pkg;

    // Controller state encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DBL   = 3'd2,
        ST_DBL_W = 3'd3,
        ST_ADDC  = 3'd4,
        ST_ADD_W = 3'd5,
        ST_NEXT  = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    // Operation select driven on pa_dbl.
    localparam logic PA_OP_ADD = 1'b0;
    localparam logic PA_OP_DBL = 1'b1;

    // Default number of cycles to wait for the point unit before giving up.
    localparam int unsigned TMO_DEFAULT = 4096;

endpackage

// File: rtl/ecc_wait_timer.sv
// Wait timer: counts enabled cycles since the last clear and flags when TMO is reached.
module ecc_wait_timer
    import ecc_pkg::*;
#(
    parameter int unsigned TMO = TMO_DEFAULT
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned TW = $clog2(TMO + 1);

    logic [TW-1:0] cnt_q;

    assign expired_o = (cnt_q == TW'(TMO));

    // Counter clears on a new unit launch and saturates at TMO while waiting.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && !expired_o) begin
            cnt_q <= cnt_q + TW'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

endmodule

// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for Q = k*P over a shared point add/double unit.
// The point at infinity is carried as an explicit flag next to the accumulator.
module scalar_mult_ctrl
    import ecc_pkg::*;
#(
    parameter int unsigned N   = 231,
    parameter int unsigned TMO = TMO_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] k,
    input  logic [N-1:0] px,
    input  logic [N-1:0] py,
    input  logic         p_inf,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] qx,
    output logic [N-1:0] qy,
    output logic         q_inf,
    output logic         err,
    output logic         pa_start,
    output logic         pa_dbl,
    output logic [N-1:0] pa_x1,
    output logic [N-1:0] pa_y1,
    output logic [N-1:0] pa_x2,
    output logic [N-1:0] pa_y2,
    input  logic         pa_done,
    input  logic [N-1:0] pa_x3,
    input  logic [N-1:0] pa_y3,
    input  logic         pa_inf
);
    localparam int unsigned IW = $clog2(N);

    state_t         state_q;
    logic [N-1:0]   k_q, px_q, py_q;
    logic           p_inf_q;
    logic [N-1:0]   acc_x_q, acc_y_q;
    logic           acc_inf_q;
    logic [IW-1:0]  idx_q;

    logic           busy_q, done_q, err_q, q_inf_q;
    logic [N-1:0]   qx_q, qy_q;
    logic           pa_start_q, pa_dbl_q;
    logic [N-1:0]   pa_x1_q, pa_y1_q, pa_x2_q, pa_y2_q;

    logic           issue_d;
    logic           waiting_d;
    logic           expired_s;

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign qx       = qx_q;
    assign qy       = qy_q;
    assign q_inf    = q_inf_q;
    assign pa_start = pa_start_q;
    assign pa_dbl   = pa_dbl_q;
    assign pa_x1    = pa_x1_q;
    assign pa_y1    = pa_y1_q;
    assign pa_x2    = pa_x2_q;
    assign pa_y2    = pa_y2_q;

    // Launch and wait qualifiers that drive the unit timeout timer.
    always_comb begin
        issue_d   = 1'b0;
        waiting_d = 1'b0;
        if ((state_q == ST_DBL) && !acc_inf_q) begin
            issue_d = 1'b1;
        end else if ((state_q == ST_ADDC) && k_q[idx_q] && !acc_inf_q) begin
            issue_d = 1'b1;
        end else begin
            issue_d = 1'b0;
        end
        waiting_d = (state_q == ST_DBL_W) || (state_q == ST_ADD_W);
    end

    ecc_wait_timer #(.TMO(TMO)) u_timer (
        .clk_i     (clk),
        .reset_i   (reset),
        .clr_i     (issue_d),
        .en_i      (waiting_d),
        .expired_o (expired_s)
    );

    // Controller FSM with registered handshake, operand and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            px_q       <= '0;
            py_q       <= '0;
            p_inf_q    <= 1'b0;
            acc_x_q    <= '0;
            acc_y_q    <= '0;
            acc_inf_q  <= 1'b1;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            qx_q       <= '0;
            qy_q       <= '0;
            q_inf_q    <= 1'b1;
            pa_start_q <= 1'b0;
            pa_dbl_q   <= 1'b0;
            pa_x1_q    <= '0;
            pa_y1_q    <= '0;
            pa_x2_q    <= '0;
            pa_y2_q    <= '0;
        end else begin
            pa_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        k_q     <= k;
                        px_q    <= px;
                        py_q    <= py;
                        p_inf_q <= p_inf;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    acc_inf_q <= 1'b1;
                    idx_q     <= IW'(N - 1);
                    err_q     <= 1'b0;
                    if (p_inf_q || (k_q == '0)) begin
                        // Trivial product: report infinity without touching the unit.
                        qx_q    <= '0;
                        qy_q    <= '0;
                        q_inf_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= ST_DBL;
                    end
                end
                ST_DBL: begin
                    if (acc_inf_q) begin
                        // Doubling infinity is infinity; skip the unit.
                        state_q <= ST_ADDC;
                    end else begin
                        pa_start_q <= 1'b1;
                        pa_dbl_q   <= PA_OP_DBL;
                        pa_x1_q    <= acc_x_q;
                        pa_y1_q    <= acc_y_q;
                        pa_x2_q    <= acc_x_q;
                        pa_y2_q    <= acc_y_q;
                        state_q    <= ST_DBL_W;
                    end
                end
                ST_ADDC: begin
                    if (!k_q[idx_q]) begin
                        state_q <= ST_NEXT;
                    end else if (acc_inf_q) begin
                        // inf + P = P; load it directly.
                        acc_x_q   <= px_q;
                        acc_y_q   <= py_q;
                        acc_inf_q <= 1'b0;
                        state_q   <= ST_NEXT;
                    end else begin
                        pa_start_q <= 1'b1;
                        pa_dbl_q   <= PA_OP_ADD;
                        pa_x1_q    <= acc_x_q;
                        pa_y1_q    <= acc_y_q;
                        pa_x2_q    <= px_q;
                        pa_y2_q    <= py_q;
                        state_q    <= ST_ADD_W;
                    end
                end
                ST_DBL_W, ST_ADD_W: begin
                    // A result arriving in the expiry cycle still counts.
                    if (pa_done) begin
                        acc_x_q   <= pa_x3;
                        acc_y_q   <= pa_y3;
                        acc_inf_q <= pa_inf;
                        state_q   <= (state_q == ST_DBL_W) ? ST_ADDC : ST_NEXT;
                    end else if (expired_s) begin
                        qx_q    <= acc_inf_q ? '0 : acc_x_q;
                        qy_q    <= acc_inf_q ? '0 : acc_y_q;
                        q_inf_q <= acc_inf_q;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        state_q <= state_q;
                    end
                end
                ST_NEXT: begin
                    if (idx_q == '0) begin
                        qx_q    <= acc_inf_q ? '0 : acc_x_q;
                        qy_q    <= acc_inf_q ? '0 : acc_y_q;
                        q_inf_q <= acc_inf_q;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q   <= idx_q - IW'(1);
                        state_q <= ST_DBL;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
